// File: rtl/demux_stream_1to4.sv
// demux_stream_1to4: routes one valid/ready packet stream to one of four channels.
// The channel is locked per packet, and a single registered stage sustains one beat per cycle.
module demux_stream_1to4 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_sel,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [3:0]        pkt_done
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        lock_sel_q, lock_sel_d;
  logic              hold_valid_q, hold_valid_d;
  logic [1:0]        hold_ch_q, hold_ch_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic [3:0]        out_valid_q, out_valid_d;
  logic [3:0]        pkt_done_q, pkt_done_d;
  logic              accept_s;
  logic              drain_s;
  logic [1:0]        ch_s;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] vec;
    case (idx)
      2'd0:    vec = 4'b0001;
      2'd1:    vec = 4'b0010;
      2'd2:    vec = 4'b0100;
      2'd3:    vec = 4'b1000;
      default: vec = 4'b0000;
    endcase
    return vec;
  endfunction

  // Handshake and routing decisions; only the addressed sink's ready matters.
  always_comb begin
    drain_s  = hold_valid_q & out_ready[hold_ch_q];
    in_ready = ~rst & (~hold_valid_q | out_ready[hold_ch_q]);
    accept_s = in_valid & in_ready;
    if (state_q == IDLE) begin
      ch_s = in_sel;
    end else begin
      ch_s = lock_sel_q;
    end
  end

  // Next-state for the packet FSM and hold stage; an accept overwrites a draining beat.
  always_comb begin
    state_d      = state_q;
    lock_sel_d   = lock_sel_q;
    hold_valid_d = hold_valid_q;
    hold_ch_d    = hold_ch_q;
    data_d       = data_q;
    last_d       = last_q;
    if (accept_s) begin
      hold_valid_d = 1'b1;
      hold_ch_d    = ch_s;
      data_d       = in_data;
      last_d       = in_last;
      case (state_q)
        IDLE: begin
          if (!in_last) begin
            state_d    = BUSY;
            lock_sel_d = in_sel;
          end else begin
            state_d = IDLE;
          end
        end
        BUSY: begin
          if (in_last) begin
            state_d = IDLE;
          end else begin
            state_d = BUSY;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (drain_s) begin
      hold_valid_d = 1'b0;
    end else begin
      hold_valid_d = hold_valid_q;
    end
    out_valid_d = hold_valid_d ? onehot4(hold_ch_d) : 4'b0000;
    pkt_done_d  = (drain_s && last_q) ? onehot4(hold_ch_q) : 4'b0000;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lock_sel_q   <= 2'd0;
      hold_valid_q <= 1'b0;
      hold_ch_q    <= 2'd0;
      data_q       <= {DATA_W{1'b0}};
      last_q       <= 1'b0;
      out_valid_q  <= 4'b0000;
      pkt_done_q   <= 4'b0000;
    end else begin
      state_q      <= state_d;
      lock_sel_q   <= lock_sel_d;
      hold_valid_q <= hold_valid_d;
      hold_ch_q    <= hold_ch_d;
      data_q       <= data_d;
      last_q       <= last_d;
      out_valid_q  <= out_valid_d;
      pkt_done_q   <= pkt_done_d;
    end
  end

  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_valid = out_valid_q;
  assign pkt_done  = pkt_done_q;

endmodule
